clock_div_multi: RTL

- Multi-channel programmable clock divider; each channel combines a rollover counter with a derived toggle clock.
- Each channel counts enabled cycles modulo a run-time divisor, emits a one-cycle rollover pulse and toggles its derived clock at every rollover.
- New divisors are applied glitch-free at a rollover boundary.
- Sits between the system clock and slow peripheral/timebase logic; replaces the single-channel fixed clock-from-rollover scheme.

---
 rtl/clock_div_multi_pkg.sv | 23 ++
 rtl/clock_div_ch.sv | 106 ++++++++++
 rtl/clock_div_multi.sv | 49 ++++
 3 files changed

// File: rtl/clock_div_multi_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Holds the per-channel state encoding, default sizing and a state helper.
// Imported by the channel and the top level.
package clock_div_multi_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } ch_state_t;

  // Divisor at the default width; the modules size their divisors by W.
  typedef logic [W_DEF-1:0] div_t;

  // A channel with a zero divisor parks in IDLE, otherwise it runs.
  function automatic ch_state_t settle_state(input logic div_is_zero);
    return div_is_zero ? IDLE : RUN;
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: rollover counter, pending-divisor register, IDLE/RUN/PEND FSM, toggle clock.
// Latency: rollover, toggle and ack are registered and appear the cycle after the deciding edge.
// No backpressure: i_en only stalls counting; a waiting load is held until the next rollover.
module clock_div_ch
  import clock_div_multi_pkg::*;
#(
  parameter int           W       = W_DEF,
  parameter logic [W-1:0] DIV_RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         load,
  input  logic         sync,
  output logic         load_ack,
  output logic         roll_over,
  output logic         clk_out
);

  ch_state_t    state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] div_act, div_nxt;
  logic [W-1:0] pend, pend_nxt;
  logic [W-1:0] apply_div;
  logic         tgl_nxt, roll_nxt, ack_nxt;
  logic         wrap, swap;

  // Next-state, counter, divisor swap and toggle decisions for this edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div_act;
    pend_nxt  = pend;
    tgl_nxt   = clk_out;
    roll_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    // A load on the swap edge itself wins over the older pending value.
    apply_div = load ? div_in : pend;
    wrap      = en && (state != IDLE) && (cnt == div_act - W'(1));
    swap      = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          div_nxt   = div_in;
          cnt_nxt   = '0;
          ack_nxt   = 1'b1;
          state_nxt = settle_state(div_in == '0);
        end
      end
      RUN, PEND: begin
        if (sync) begin
          // Phase realignment: restart the period low, no rollover reported.
          cnt_nxt = '0;
          tgl_nxt = 1'b0;
          swap    = load || (state == PEND);
        end else begin
          if (wrap) begin
            cnt_nxt  = '0;
            roll_nxt = 1'b1;
            tgl_nxt  = ~clk_out;
          end else if (en) begin
            cnt_nxt = cnt + W'(1);
          end
          swap = wrap && (load || (state == PEND));
          if (!swap && load) begin
            pend_nxt  = div_in;
            state_nxt = PEND;
          end
        end
        if (swap) begin
          div_nxt   = apply_div;
          ack_nxt   = 1'b1;
          state_nxt = settle_state(apply_div == '0);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= settle_state(DIV_RST == '0);
      cnt       <= '0;
      div_act   <= DIV_RST;
      pend      <= '0;
      clk_out   <= 1'b0;
      roll_over <= 1'b0;
      load_ack  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      div_act   <= div_nxt;
      pend      <= pend_nxt;
      clk_out   <= tgl_nxt;
      roll_over <= roll_nxt;
      load_ack  <= ack_nxt;
    end
  end

endmodule

// File: rtl/clock_div_multi.sv
// N_CH independent programmable dividers; optional i_sync phase-align input under CLOCK_DIV_MULTI_SYNC_EN.
// Latency: outputs registered, one cycle after the edge that decides them.
// No backpressure: loads taken in IDLE immediately, otherwise held pending to the next rollover.
module clock_div_multi
  import clock_div_multi_pkg::*;
#(
  parameter int          N_CH    = N_CH_DEF,
  parameter int          W       = W_DEF,
  parameter int unsigned DIV_RST = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [N_CH-1:0]   i_en,
  input  logic [N_CH*W-1:0] i_div,
  input  logic [N_CH-1:0]   i_load,
`ifdef CLOCK_DIV_MULTI_SYNC_EN
  input  logic              i_sync,
`endif
  output logic [N_CH-1:0]   o_load_ack,
  output logic [N_CH-1:0]   o_roll_over,
  output logic [N_CH-1:0]   o_clk
);

  logic sync_req;

`ifdef CLOCK_DIV_MULTI_SYNC_EN
  assign sync_req = i_sync;
`else
  assign sync_req = 1'b0;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clock_div_ch #(
      .W       (W),
      .DIV_RST (W'(DIV_RST))
    ) u_ch (
      .clk       (i_clk),
      .rst_n     (i_reset_n),
      .en        (i_en[c]),
      .div_in    (i_div[c*W +: W]),
      .load      (i_load[c]),
      .sync      (sync_req),
      .load_ack  (o_load_ack[c]),
      .roll_over (o_roll_over[c]),
      .clk_out   (o_clk[c])
    );
  end

endmodule
